fetch_unit: RTL and testbench

//  Instruction fetch stage directly downstream of the program counter. Takes the

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches on a req/gnt/rvalid bus under a
// credit limit, buffers responses in order and hands {instr, pc} to decode.
module fetch_unit #(
  parameter int          XLEN       = 32,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_ready_out,
  input  logic            flush_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [31:0]     imem_rdata_in,
  input  logic            id_ready_in,
  output logic            instr_valid_out,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] instr_pc_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   fifo_count_q, fifo_count_d;
  logic [PW-1:0]   aq_wptr_q, aq_rptr_q;
  logic [PW-1:0]   of_wptr_q, of_rptr_q;
  logic [XLEN-1:0] aq_pc_q    [FIFO_DEPTH];
  logic [31:0]     of_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] of_pc_q    [FIFO_DEPTH];

  logic [CW-1:0]   in_use;
  logic            grant;
  logic            keep_rsp;
  logic            pop;

  always_comb begin
    in_use          = outstanding_q + fifo_count_q;
    // Request only while no stale responses are pending and a slot is guaranteed.
    imem_req_out    = rst_n && (state_q == RUN) && (in_use < CW'(FIFO_DEPTH)) && !flush_in;
    imem_addr_out   = {pc_in[XLEN-1:2], 2'b00};
    grant           = imem_req_out && imem_gnt_in;
    pc_ready_out    = grant;
    keep_rsp        = imem_rvalid_in && (state_q == RUN) && !flush_in;
    instr_valid_out = (fifo_count_q != '0) && !flush_in;
    pop             = instr_valid_out && id_ready_in;
    instr_out       = instr_valid_out ? of_instr_q[of_rptr_q] : NOP_INSTR;
    instr_pc_out    = instr_valid_out ? of_pc_q[of_rptr_q] : '0;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({grant, imem_rvalid_in})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    fifo_count_d = fifo_count_q;
    if (flush_in) begin
      fifo_count_d = '0;
    end else begin
      case ({keep_rsp, pop})
        2'b10:   fifo_count_d = fifo_count_q + CW'(1);
        2'b01:   fifo_count_d = fifo_count_q - CW'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
    end

    // Judge on the post-cycle count so a response landing in the flush cycle
    // cannot strand the FSM in DRAIN with nothing left to wait for.
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_in && (outstanding_d != '0)) state_d = DRAIN;
      DRAIN:   if (outstanding_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      aq_wptr_q     <= '0;
      aq_rptr_q     <= '0;
      of_wptr_q     <= '0;
      of_rptr_q     <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      if (grant)          aq_wptr_q <= aq_wptr_q + PW'(1);
      if (imem_rvalid_in) aq_rptr_q <= aq_rptr_q + PW'(1);
      if (flush_in) begin
        of_wptr_q <= '0;
        of_rptr_q <= '0;
      end else begin
        if (keep_rsp) of_wptr_q <= of_wptr_q + PW'(1);
        if (pop)      of_rptr_q <= of_rptr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset: every read is qualified by a count.
  always_ff @(posedge clk) begin
    if (grant) aq_pc_q[aq_wptr_q] <= pc_in;
    if (keep_rsp) begin
      of_instr_q[of_wptr_q] <= imem_rdata_in;
      of_pc_q[of_wptr_q]    <= aq_pc_q[aq_rptr_q];
    end
  end

  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_in |-> (outstanding_q != '0));

  a_pc_stable_until_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_out && !imem_gnt_in) |=> ($stable(pc_in) || flush_in));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_ready_out;
  logic        flush_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        id_ready_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.XLEN(32), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_in(pc_in), .pc_ready_out(pc_ready_out), .flush_in(flush_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in),
    .imem_rdata_in(imem_rdata_in), .id_ready_in(id_ready_in),
    .instr_valid_out(instr_valid_out), .instr_out(instr_out),
    .instr_pc_out(instr_pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        idr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_rdy;
    logic        exp_val;
    logic [31:0] exp_instr;
    logic [31:0] exp_ipc;
  } vec_t;

  typedef struct { logic [31:0] pc; bit stale; } pend_t;
  typedef struct { logic [31:0] ins; logic [31:0] pc; } obuf_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [31:0] pc, input logic g, input logic rv,
                     input logic [31:0] rd, input logic idr, input logic fl);
    pc_in = pc; imem_gnt_in = g; imem_rvalid_in = rv;
    imem_rdata_in = rd; id_ready_in = idr; flush_in = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    put(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [13];

  initial begin
    // cycle-exact vectors: streaming fill (credit limit 2) then a 3-cycle gnt stall on 0x100
    tbl[0]  = '{32'h000, 1, 0, 32'h0,         1, 1, 32'h000, 1, 0, NOP,           32'h0};
    tbl[1]  = '{32'h004, 1, 1, 32'hA000_0000, 1, 1, 32'h004, 1, 0, NOP,           32'h0};
    tbl[2]  = '{32'h008, 1, 1, 32'hA000_0004, 1, 0, 32'h008, 0, 1, 32'hA000_0000, 32'h0};
    tbl[3]  = '{32'h008, 1, 0, 32'h0,         1, 1, 32'h008, 1, 1, 32'hA000_0004, 32'h4};
    tbl[4]  = '{32'h00C, 1, 1, 32'hA000_0008, 1, 1, 32'h00C, 1, 0, NOP,           32'h0};
    tbl[5]  = '{32'h010, 1, 1, 32'hA000_000C, 1, 0, 32'h010, 0, 1, 32'hA000_0008, 32'h8};
    tbl[6]  = '{32'h010, 1, 0, 32'h0,         1, 1, 32'h010, 1, 1, 32'hA000_000C, 32'hC};
    tbl[7]  = '{32'h100, 0, 1, 32'hA000_0010, 1, 1, 32'h100, 0, 0, NOP,           32'h0};
    tbl[8]  = '{32'h100, 0, 0, 32'h0,         0, 1, 32'h100, 0, 1, 32'hA000_0010, 32'h10};
    tbl[9]  = '{32'h100, 0, 0, 32'h0,         1, 1, 32'h100, 0, 1, 32'hA000_0010, 32'h10};
    tbl[10] = '{32'h100, 1, 0, 32'h0,         1, 1, 32'h100, 1, 0, NOP,           32'h0};
    tbl[11] = '{32'h104, 0, 1, 32'hA000_0100, 1, 1, 32'h104, 0, 0, NOP,           32'h0};
    tbl[12] = '{32'h104, 0, 0, 32'h0,         1, 1, 32'h104, 0, 1, 32'hA000_0100, 32'h100};

    // reset values, with gnt high to show req is held off
    rst_n = 1'b0;
    put(32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("rst_req", 32'(imem_req_out), 32'h0);
    chk("rst_pc_ready", 32'(pc_ready_out), 32'h0);
    chk("rst_valid", 32'(instr_valid_out), 32'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_instr_pc", instr_pc_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      put(tbl[i].pc, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].idr, 1'b0);
      #1;
      chk($sformatf("vec%0d_req", i), 32'(imem_req_out), 32'(tbl[i].exp_req));
      chk($sformatf("vec%0d_addr", i), imem_addr_out, tbl[i].exp_addr);
      chk($sformatf("vec%0d_pc_ready", i), 32'(pc_ready_out), 32'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid_out), 32'(tbl[i].exp_val));
      chk($sformatf("vec%0d_instr", i), instr_out, tbl[i].exp_instr);
      chk($sformatf("vec%0d_instr_pc", i), instr_pc_out, tbl[i].exp_ipc);
      $display("vec %0d: pc=%h req=%b valid=%b instr=%h instr_pc=%h",
               i, tbl[i].pc, imem_req_out, instr_valid_out, instr_out, instr_pc_out);
      @(negedge clk);
    end

    // reset in the middle of a fetch with one instruction buffered
    put(32'h104, 1, 0, 32'h0, 0, 0); @(negedge clk);
    put(32'h108, 0, 1, 32'hBEEF_0104, 0, 0); @(negedge clk);
    put(32'h108, 0, 0, 32'h0, 0, 0); #1;
    chk("midrst_pre_valid", 32'(instr_valid_out), 32'h1);
    rst_n = 1'b0;
    put(32'h108, 1, 0, 32'h0, 0, 0); #1;
    chk("midrst_req", 32'(imem_req_out), 32'h0);
    chk("midrst_pc_ready", 32'(pc_ready_out), 32'h0);
    chk("midrst_valid", 32'(instr_valid_out), 32'h0);
    chk("midrst_instr", instr_out, NOP);
    chk("midrst_instr_pc", instr_pc_out, 32'h0);
    $display("mid-fetch reset: req=%b valid=%b instr=%h", imem_req_out, instr_valid_out, instr_out);
    @(negedge clk);
    rst_n = 1'b1;
    put(32'h0, 0, 0, 32'h0, 1, 0);
    @(negedge clk);

    // back-pressure: decode stalled 5 cycles, memory answers one cycle after gnt
    begin
      int grants = 0;
      int got = 0;
      bit seen_grant = 0;
      logic last_req = 1'b1;
      logic [31:0] first_pc = 32'hFFFF_FFFF;
      logic [31:0] bq[$];
      logic [31:0] pcv = 32'h0;
      logic rv, g_now;
      for (int c = 0; c < 5; c++) begin
        rv = (bq.size() > 0);
        put(pcv, 1, rv, rv ? (bq[0] ^ 32'h5EED_0000) : 32'h0, 0, 0);
        #1;
        g_now = pc_ready_out;
        last_req = imem_req_out;
        if (g_now) grants++;
        @(negedge clk);
        if (rv) void'(bq.pop_front());
        if (g_now) begin bq.push_back(pcv); pcv += 4; end
      end
      chk("bp_grants", 32'(grants), 32'd2);
      chk("bp_req_dropped", 32'(last_req), 32'h0);
      for (int c = 0; c < 10 && !(got >= 2 && seen_grant); c++) begin
        rv = (bq.size() > 0);
        put(pcv, 1, rv, rv ? (bq[0] ^ 32'h5EED_0000) : 32'h0, 1, 0);
        #1;
        g_now = pc_ready_out;
        if (instr_valid_out && got < 2) begin
          chk($sformatf("bp_pc%0d", got), instr_pc_out, 32'(got * 4));
          chk($sformatf("bp_instr%0d", got), instr_out, 32'(got * 4) ^ 32'h5EED_0000);
          got++;
        end
        if (g_now && !seen_grant) begin seen_grant = 1; first_pc = pcv; end
        @(negedge clk);
        if (rv) void'(bq.pop_front());
        if (g_now) begin bq.push_back(pcv); pcv += 4; end
      end
      chk("bp_delivered", 32'(got), 32'd2);
      chk("bp_resume_pc", first_pc, 32'h8);
      $display("back-pressure: grants=%0d delivered=%0d resume_pc=%h", grants, got, first_pc);
    end

    // flush with two fetches outstanding
    do_reset();
    put(32'h0, 1, 0, 32'h0, 1, 0); #1; chk("fl_g0", 32'(pc_ready_out), 32'h1); @(negedge clk);
    put(32'h4, 1, 0, 32'h0, 1, 0); #1; chk("fl_g1", 32'(pc_ready_out), 32'h1); @(negedge clk);
    put(32'h8, 0, 0, 32'h0, 1, 0); #1; chk("fl_full_req", 32'(imem_req_out), 32'h0); @(negedge clk);
    put(32'h200, 0, 0, 32'h0, 1, 1); #1;
    chk("fl_req", 32'(imem_req_out), 32'h0);
    chk("fl_valid", 32'(instr_valid_out), 32'h0);
    chk("fl_instr", instr_out, NOP);
    @(negedge clk);
    put(32'h200, 1, 1, 32'hDEAD_0000, 1, 0); #1;
    chk("drain1_req", 32'(imem_req_out), 32'h0);
    chk("drain1_valid", 32'(instr_valid_out), 32'h0);
    @(negedge clk);
    put(32'h200, 1, 1, 32'hDEAD_0004, 1, 0); #1;
    chk("drain2_req", 32'(imem_req_out), 32'h0);
    chk("drain2_valid", 32'(instr_valid_out), 32'h0);
    @(negedge clk);
    put(32'h200, 1, 0, 32'h0, 1, 0); #1;
    chk("refetch_req", 32'(imem_req_out), 32'h1);
    chk("refetch_addr", imem_addr_out, 32'h200);
    chk("refetch_valid", 32'(instr_valid_out), 32'h0);
    @(negedge clk);
    put(32'h204, 0, 1, 32'hC0DE_0200, 1, 0); #1;
    chk("refetch_rsp_valid", 32'(instr_valid_out), 32'h0);
    @(negedge clk);
    put(32'h204, 0, 0, 32'h0, 1, 0); #1;
    chk("after_flush_valid", 32'(instr_valid_out), 32'h1);
    chk("after_flush_pc", instr_pc_out, 32'h200);
    chk("after_flush_instr", instr_out, 32'hC0DE_0200);
    $display("flush/drain: delivered pc=%h instr=%h", instr_pc_out, instr_out);
    @(negedge clk);

    // randomized run against the reference model
    do_reset();
    begin
      pend_t pend[$];
      obuf_t ob[$];
      pend_t p;
      logic [31:0] rpc = 32'h1000;
      logic fl, g, rv, idr, e_req, e_val;
      logic [31:0] rd;
      bit any_stale;
      int delivered = 0;
      for (int c = 0; c < 3000; c++) begin
        fl  = ($urandom_range(0, 15) == 0);
        if (fl) rpc = $urandom;
        g   = ($urandom_range(0, 2) != 0);
        rv  = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
        rd  = $urandom;
        idr = ($urandom_range(0, 3) != 0);
        put(rpc, g, rv, rd, idr, fl);
        #1;
        any_stale = 0;
        foreach (pend[i]) if (pend[i].stale) any_stale = 1;
        e_req = !any_stale && (pend.size() + ob.size() < DEPTH) && !fl;
        e_val = (ob.size() > 0) && !fl;
        chk("rnd_req", 32'(imem_req_out), 32'(e_req));
        chk("rnd_addr", imem_addr_out, rpc & 32'hFFFF_FFFC);
        chk("rnd_pc_ready", 32'(pc_ready_out), 32'(e_req && g));
        chk("rnd_valid", 32'(instr_valid_out), 32'(e_val));
        chk("rnd_instr", instr_out, e_val ? ob[0].ins : NOP);
        chk("rnd_instr_pc", instr_pc_out, e_val ? ob[0].pc : 32'h0);
        if (e_val && idr) begin void'(ob.pop_front()); delivered++; end
        if (rv) begin
          p = pend.pop_front();
          if (!p.stale && !fl) ob.push_back('{rd, p.pc});
        end
        if (fl) begin
          ob.delete();
          foreach (pend[i]) pend[i].stale = 1;
        end
        if (e_req && g) begin
          pend.push_back('{rpc, 1'b0});
          rpc += 4;
        end
        @(negedge clk);
      end
      $display("random run: %0d instructions delivered", delivered);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
